// File: rtl/crc_pkg.sv
// Shared CRC definitions: named generator polynomials and checker FSM state encoding.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package crc_pkg;

  // Generator polynomials, implicit x^W term omitted.
  localparam logic [7:0]  CRC8_SMBUS  = 8'h07;
  localparam logic [15:0] CRC16_CCITT = 16'h1021;
  localparam logic [31:0] CRC32       = 32'h04C11DB7;

  // Frame checker states: RUN means a frame is open.
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/crc_step.sv
// Combinational CRC step: folds DATA_W bits (MSB first) into a CRC_W-bit LFSR.
// Latency: zero (purely combinational, DATA_W serial steps unrolled).
// Backpressure: none; output follows inputs.
// Ports:
//   crc_in   [CRC_W-1:0]  current LFSR value
//   din      [DATA_W-1:0] data bits, din[DATA_W-1] shifted in first
//   crc_next [CRC_W-1:0]  LFSR value after all DATA_W bits
module crc_step
  import crc_pkg::*;
#(
  parameter int               CRC_W  = 8,
  parameter logic [CRC_W-1:0] POLY   = CRC8_SMBUS,
  parameter int               DATA_W = 1
) (
  input  logic [CRC_W-1:0]  crc_in,
  input  logic [DATA_W-1:0] din,
  output logic [CRC_W-1:0]  crc_next
);

  logic [CRC_W-1:0] c;
  logic             fb;

  always_comb begin
    c  = crc_in;
    fb = 1'b0;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      fb = c[CRC_W-1] ^ din[i];
      c  = {c[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
    end
    crc_next = c;
  end

endmodule

// File: rtl/crc_frame_checker.sv
// Framed CRC checker/generator: folds DATA_W bits per beat between sof and eof, reports CRC,
// residue match and frame length. Latency: results registered on the eof accept edge (1 cycle).
// Backpressure: none; every din_valid beat is consumed, back-to-back frames run at full rate.
// Ports:
//   clk, rst             clock, async active-high reset
//   din_valid, sof, eof  beat qualifier and framing (framing ignored without din_valid)
//   din [DATA_W-1:0]     beat data, MSB processed first
//   residue [CRC_W-1:0]  expected raw remainder, sampled on the eof beat
//   busy                 frame open
//   crc_out [CRC_W-1:0]  final CRC ^ XOR_OUT, held until next frame completes
//   crc_done             one-cycle pulse after the eof beat
//   crc_valid            raw final CRC == residue, cleared by next sof
//   frame_len [LEN_W-1:0] beats in last frame, saturating
module crc_frame_checker
  import crc_pkg::*;
#(
  parameter int               CRC_W   = 8,
  parameter logic [CRC_W-1:0] POLY    = CRC8_SMBUS,
  parameter logic [CRC_W-1:0] INIT    = '0,
  parameter logic [CRC_W-1:0] XOR_OUT = '0,
  parameter int               DATA_W  = 1,
  parameter int               LEN_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              din_valid,
  input  logic              sof,
  input  logic              eof,
  input  logic [DATA_W-1:0] din,
  input  logic [CRC_W-1:0]  residue,
  output logic              busy,
  output logic [CRC_W-1:0]  crc_out,
  output logic              crc_done,
  output logic              crc_valid,
  output logic [LEN_W-1:0]  frame_len
);

  localparam logic [LEN_W-1:0] LEN_MAX = '1;
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  state_t           state;
  logic [CRC_W-1:0] lfsr;
  logic [LEN_W-1:0] count;

  logic [CRC_W-1:0] base;
  logic [CRC_W-1:0] next;
  logic [LEN_W-1:0] count_next;
  logic             accept;

  // sof always restarts from INIT, even mid-frame; this is also how an aborted
  // frame is dropped without ever producing crc_done.
  assign base   = sof ? INIT : lfsr;
  // Outside a frame only a sof beat does anything.
  assign accept = din_valid && (sof || (state == RUN));

  always_comb begin
    count_next = count;
    if (sof) begin
      count_next = LEN_ONE;
    end else if (count != LEN_MAX) begin
      count_next = count + LEN_ONE;
    end
  end

  crc_step #(
    .CRC_W  (CRC_W),
    .POLY   (POLY),
    .DATA_W (DATA_W)
  ) u_step (
    .crc_in   (base),
    .din      (din),
    .crc_next (next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      lfsr      <= INIT;
      count     <= '0;
      crc_out   <= '0;
      crc_done  <= 1'b0;
      crc_valid <= 1'b0;
      frame_len <= '0;
    end else begin
      crc_done <= 1'b0;
      if (accept) begin
        lfsr  <= next;
        count <= count_next;
        if (sof) begin
          crc_valid <= 1'b0;
        end
        // eof assignments come last so a single-beat sof+eof frame reports its own result.
        if (eof) begin
          state     <= IDLE;
          busy      <= 1'b0;
          crc_done  <= 1'b1;
          crc_out   <= next ^ XOR_OUT;
          crc_valid <= (next == residue);
          frame_len <= count_next;
        end else begin
          state <= RUN;
          busy  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_crc_frame_checker.sv
// Directed self-checking bench: byte-wide and bit-serial CRC-8 checkers against
// hand-computed CRC-8/0x07 values.
module tb_crc_frame_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // Byte-wide instance
  logic        v8 = 1'b0, s8 = 1'b0, e8 = 1'b0;
  logic [7:0]  d8 = 8'h00, res8 = 8'h00;
  logic        busy8, done8, valid8;
  logic [7:0]  out8;
  logic [15:0] len8;

  // Bit-serial instance with a narrow length counter to reach saturation
  logic        v1 = 1'b0, s1 = 1'b0, e1 = 1'b0;
  logic [0:0]  d1 = 1'b0;
  logic [7:0]  res1 = 8'h00;
  logic        busy1, done1, valid1;
  logic [7:0]  out1;
  logic [3:0]  len1;

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;
  int done_at[$];

  always #5 clk = ~clk;

  crc_frame_checker #(
    .CRC_W(8), .POLY(8'h07), .INIT(8'h00), .XOR_OUT(8'h00), .DATA_W(8), .LEN_W(16)
  ) u8 (
    .clk(clk), .rst(rst), .din_valid(v8), .sof(s8), .eof(e8), .din(d8), .residue(res8),
    .busy(busy8), .crc_out(out8), .crc_done(done8), .crc_valid(valid8), .frame_len(len8)
  );

  crc_frame_checker #(
    .CRC_W(8), .POLY(8'h07), .INIT(8'h00), .XOR_OUT(8'h00), .DATA_W(1), .LEN_W(4)
  ) u1 (
    .clk(clk), .rst(rst), .din_valid(v1), .sof(s1), .eof(e1), .din(d1), .residue(res1),
    .busy(busy1), .crc_out(out1), .crc_done(done1), .crc_valid(valid1), .frame_len(len1)
  );

  // Record the cycle index of every byte-wide crc_done pulse.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (done8) done_at.push_back(cyc);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic beat8(input logic s, input logic e, input logic [7:0] d);
    v8 = 1'b1; s8 = s; e8 = e; d8 = d;
    @(posedge clk);
    #1;
    v8 = 1'b0; s8 = 1'b0; e8 = 1'b0;
  endtask

  task automatic beat1(input logic s, input logic e, input logic b);
    v1 = 1'b1; s1 = s; e1 = e; d1 = b;
    @(posedge clk);
    #1;
    v1 = 1'b0; s1 = 1'b0; e1 = 1'b0;
  endtask

  // "123456789", optionally followed by one appended byte carrying eof.
  task automatic frame123(input bit gaps, input bit app, input logic [7:0] app_byte);
    logic [7:0] msg [10];
    int n;
    for (int i = 0; i < 9; i++) msg[i] = 8'h31 + 8'(i);
    msg[9] = app_byte;
    n = app ? 10 : 9;
    for (int i = 0; i < n; i++) begin
      if (gaps && i > 0) repeat ($urandom_range(0, 2)) idle_cyc();
      beat8(i == 0, i == n - 1, msg[i]);
    end
  endtask

  // Sends bytes bit-serially MSB first; sof on first bit, eof on last.
  task automatic bits1(input logic [15:0] data, input int nbits);
    for (int i = nbits - 1; i >= 0; i--) begin
      beat1(i == nbits - 1, i == 0, data[i]);
    end
  endtask

  initial begin
    int n0;

    // Reset state
    #12;
    chk("rst_busy", busy8, 0);
    chk("rst_crc_out", out8, 0);
    chk("rst_done", done8, 0);
    chk("rst_valid", valid8, 0);
    chk("rst_len", len8, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle_cyc();

    // 1: check value of "123456789"
    frame123(0, 0, 8'h00);
    chk("t1_done", done8, 1);
    chk("t1_crc", out8, 8'hF4);
    chk("t1_len", len8, 9);
    chk("t1_busy", busy8, 0);
    idle_cyc();
    chk("t1_done_pulse", done8, 0);
    chk("t1_crc_hold", out8, 8'hF4);

    // 2: CRC appended -> zero remainder; corrupted append -> mismatch
    res8 = 8'h00;
    frame123(0, 1, 8'hF4);
    chk("t2_valid", valid8, 1);
    chk("t2_crc", out8, 8'h00);
    chk("t2_len", len8, 10);
    beat8(1, 0, 8'h31);
    chk("t2_sof_clears_valid", valid8, 0);
    chk("t2_crc_held", out8, 8'h00);
    chk("t2_busy", busy8, 1);
    frame123(0, 1, 8'hF5);
    chk("t2_bad_valid", valid8, 0);
    chk("t2_bad_crc", out8, 8'h07);

    // 3: bit-serial 0x31
    bits1(16'h0031, 8);
    chk("t3_done", done1, 1);
    chk("t3_crc", out1, 8'h97);
    chk("t3_len", len1, 8);

    // frame_len saturation on the 4-bit counter; CRC of "12" unaffected
    bits1(16'h3132, 16);
    chk("sat_len", len1, 15);
    chk("sat_crc", out1, 8'h72);

    // 4: beats before sof ignored, gaps inside the frame
    beat8(0, 0, 8'hAA);
    beat8(0, 1, 8'h55);
    chk("t4_ignored_busy", busy8, 0);
    chk("t4_ignored_done", done8, 0);
    frame123(1, 0, 8'h00);
    chk("t4_gap_crc", out8, 8'hF4);
    chk("t4_gap_len", len8, 9);

    // 5: aborted frame produces no done; then back-to-back frames
    n0 = done_at.size();
    beat8(1, 0, 8'h12);
    beat8(0, 0, 8'h34);
    beat8(0, 0, 8'h56);
    frame123(0, 0, 8'h00);
    idle_cyc();
    chk("t5_one_done", done_at.size() - n0, 1);
    chk("t5_crc", out8, 8'hF4);
    chk("t5_len", len8, 9);
    n0 = done_at.size();
    frame123(0, 0, 8'h00);
    frame123(0, 0, 8'h00);
    idle_cyc();
    chk("t5_b2b_count", done_at.size() - n0, 2);
    if (done_at.size() - n0 == 2)
      chk("t5_b2b_gap", done_at[n0 + 1] - done_at[n0], 9);

    // 6: asynchronous reset mid-frame
    beat8(1, 0, 8'h31);
    beat8(0, 0, 8'h32);
    chk("t6_busy_before", busy8, 1);
    #3;
    rst = 1'b1;
    #1;
    chk("t6_rst_busy", busy8, 0);
    chk("t6_rst_crc", out8, 0);
    chk("t6_rst_len", len8, 0);
    chk("t6_rst_valid", valid8, 0);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    frame123(0, 0, 8'h00);
    chk("t6_after_crc", out8, 8'hF4);
    chk("t6_after_len", len8, 9);

    idle_cyc();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
